instr_fetch_unit: RTL and testbench

//  Fetch stage that feeds the single-cycle core's datapath and decode. It owns the PC, issues one word read
//  at a time to instruction memory, and buffers responses in a small in-order FIFO. It presents
//  {instruction, pc, opcode/funct3/funct7 slices} downstream with a valid/ready handshake.
//  A redirect input (branch/jump target) flushes the FIFO and discards any in-flight response.

---
 rtl/instr_fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, keeps at most one word read in flight to
// instruction memory, and buffers responses in a small in-order FIFO whose head
// is presented downstream with a valid/ready handshake. A redirect reloads the
// PC, empties the FIFO and discards any response still in flight.
// Optional build macro: IFU_STALL_CNT_EN adds a saturating stall_count output
// that counts cycles with no instruction available.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [6:0]  inst_opcode,
    output logic [2:0]  inst_funct3,
    output logic [6:0]  inst_funct7
`ifdef IFU_STALL_CNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      NOP_INST = 32'h0000_0013;
    localparam logic [31:0]      ALIGN_M  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [31:0]      pc_q;
    logic [31:0]      req_pc_q;
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             issue;
    logic             push;
    logic             pop;
    logic             fifo_nonempty;

    assign fifo_nonempty = (count_q != '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, request issue and response acceptance; redirect never lets a response in
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        issue    = 1'b0;
        push     = 1'b0;
        case (state_q)
            FETCH: begin
                // A free slot is reserved at issue so a later push can never overflow
                if (!reset && !redirect_valid && (count_q < DEPTH_C)) begin
                    imem_req = 1'b1;
                    issue    = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push    = !redirect_valid;
                    state_d = FETCH;
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                // The stale response retires the outstanding read whether or not a redirect coincides
                if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Consumer handshake; a pop alongside a redirect is void because the FIFO is flushed
    assign pop = fifo_nonempty && inst_ready && !redirect_valid;

    // PC, request tag and FIFO bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC & ALIGN_M;
            req_pc_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            pc_q     <= redirect_pc & ALIGN_M;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (issue) begin
                req_pc_q <= pc_q;
                pc_q     <= pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are only observed while counted valid, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign imem_addr   = pc_q;
    assign inst_valid  = fifo_nonempty;
    assign inst_out    = fifo_nonempty ? fifo_data_q[rd_ptr_q] : NOP_INST;
    assign inst_pc     = fifo_nonempty ? fifo_pc_q[rd_ptr_q] : 32'h0000_0000;
    assign inst_opcode = inst_out[6:0];
    assign inst_funct3 = inst_out[14:12];
    assign inst_funct7 = inst_out[31:25];

`ifdef IFU_STALL_CNT_EN
    // Saturating count of cycles in which no instruction is offered downstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!fifo_nonempty && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory with in-order random latency, a queue-based
// reference of the instruction buffer, and directed plus randomized scenarios.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [6:0]  inst_opcode;
    logic [2:0]  inst_funct3;
    logic [6:0]  inst_funct7;
`ifdef IFU_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_opcode    (inst_opcode),
        .inst_funct3    (inst_funct3),
        .inst_funct7    (inst_funct7)
`ifdef IFU_STALL_CNT_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } mreq_t;

    mreq_t       pend[$];      // reads issued to memory, in order
    logic [31:0] mq[$];        // reference buffer: PCs of buffered instructions
    int unsigned cyc      = 0;
    int unsigned epoch    = 0;
    logic [31:0] exp_pc   = RESET_PC;
    int          checks   = 0;
    int          errors   = 0;
    int          consumed = 0;
    int          reqs     = 0;
    logic        last_req = 1'b0;
    logic [31:0] last_req_addr = '0;
    logic [31:0] req_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic will_deliver();
        return (pend.size() != 0) && (cyc >= pend[0].due);
    endfunction

    // One clock cycle: called at a negedge, returns at the next negedge
    task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt,
                        input int unsigned lat, input logic stale);
        logic        dlv;
        logic        exp_valid;
        logic [31:0] hpc;
        logic [31:0] hdata;
        mreq_t       r;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        dlv            = will_deliver();
        imem_rvalid    = dlv | stale;
        imem_rdata     = dlv ? (pend[0].addr ^ KEY) : 32'hDEAD_BEEF;
        #1;
        exp_valid = (mq.size() != 0);
        hpc       = exp_valid ? mq[0] : 32'h0;
        hdata     = exp_valid ? (mq[0] ^ KEY) : NOP_INST;
        check("inst_valid", 32'(inst_valid), 32'(exp_valid));
        check("inst_pc", inst_pc, hpc);
        check("inst_out", inst_out, hdata);
        check("opcode", 32'(inst_opcode), 32'(hdata[6:0]));
        check("funct3", 32'(inst_funct3), 32'(hdata[14:12]));
        check("funct7", 32'(inst_funct7), 32'(hdata[31:25]));
        check("imem_addr", imem_addr, exp_pc);
        if (imem_req) begin
            check("one_outstanding", 32'(pend.size()), 32'd0);
            check("req_room", 32'(mq.size() < DEPTH), 32'd1);
            check("req_during_redirect", 32'(redir), 32'd0);
        end
        last_req = imem_req;
        // Reference update for the coming edge
        if (redir) begin
            mq.delete();
            epoch++;
            exp_pc = tgt & 32'hFFFF_FFFC;
        end else begin
            if (exp_valid && rdy) begin
                void'(mq.pop_front());
                consumed++;
            end
            if (dlv && (pend[0].epoch == epoch)) mq.push_back(pend[0].addr);
        end
        if (dlv) void'(pend.pop_front());
        if (imem_req) begin
            r.addr  = exp_pc;
            r.epoch = epoch;
            r.due   = cyc + lat;
            pend.push_back(r);
            last_req_addr = exp_pc;
            req_log.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
            reqs++;
        end
        cyc++;
        @(negedge clk);
    endtask

    // Asynchronous reset with immediate output check; returns at a negedge with reset released
    task automatic do_reset();
        #1;
        reset          = 1'b1;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_out", inst_out, NOP_INST);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_opcode", 32'(inst_opcode), 32'h13);
`ifdef IFU_STALL_CNT_EN
        check("rst_stall_count", stall_count, 32'd0);
`endif
        mq.delete();
        pend.delete();
        req_log.delete();
        epoch++;
        exp_pc   = RESET_PC;
        consumed = 0;
        reqs     = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;

        // Streaming with 1-cycle memory and an always-ready consumer
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0, 1, 1'b0);
        check("t1_consumed", 32'(consumed), 32'd9);
        check("t1_reqs", 32'(reqs), 32'd10);

        // Back-pressure fills the buffer, then drains in order
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1, 1'b0);
        check("t2_reqs_full", 32'(reqs), 32'd2);
        check("t2_no_req_full", 32'(last_req), 32'd0);
        consumed = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1, 1'b0);
        check("t2_drain", 32'(consumed), 32'd6);

        // Redirect while waiting; the late response must be dropped
        do_reset();
        step(1'b1, 1'b0, 32'h0, 4, 1'b0);
        step(1'b1, 1'b1, 32'h100, 1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1, 1'b0);
        check("t3_req_count", 32'(req_log.size() >= 2), 32'd1);
        if (req_log.size() >= 2) check("t3_redirect_addr", req_log[1], 32'h100);

        // Redirect coinciding with a response and a consumer handshake
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (inst_valid && will_deliver()) begin
                found = 1'b1;
                step(1'b1, 1'b1, 32'h203, 1, 1'b0);
            end else begin
                step(1'b0, 1'b0, 32'h0, 1, 1'b0);
            end
        end
        check("t4_reached", 32'(found), 32'd1);
        step(1'b1, 1'b0, 32'h0, 1, 1'b0);
        check("t4_next_req", 32'(last_req), 32'd1);
        check("t4_next_addr", last_req_addr, 32'h200);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1, 1'b0);

        // Reset during WAIT with a buffered entry, then a stale response
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 3, 1'b0);
        check("t5_pre_valid", 32'(inst_valid), 32'd1);
        do_reset();
        step(1'b1, 1'b0, 32'h0, 2, 1'b1);
        check("t5_restart_addr", last_req_addr, RESET_PC);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1, 1'b0);

        // PC wrap at the top of the address space
        do_reset();
        step(1'b1, 1'b1, 32'hFFFF_FFFA, 1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0, 1, 1'b0);
        check("wrap_third_addr", 32'(req_log.size() >= 3), 32'd1);
        if (req_log.size() >= 3) check("wrap_addr", req_log[2], 32'h0);

`ifdef IFU_STALL_CNT_EN
        // Stall counter while memory is silent after the first request
        do_reset();
        step(1'b1, 1'b0, 32'h0, 5, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1, 1'b0);
        check("stall_first_valid", 32'(inst_valid), 32'd1);
        check("stall_count", stall_count, 32'd6);
`endif

        // Randomized traffic: variable latency, back-pressure, redirects and rare resets
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(499, 0) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(9, 0) < 7) ? 1'b1 : 1'b0,
                     ($urandom_range(24, 0) == 0) ? 1'b1 : 1'b0,
                     $urandom() & 32'h0000_FFFF,
                     $urandom_range(4, 1), 1'b0);
            end
        end
        check("rand_progress", 32'(reqs > 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
